// File: rtl/replay_uart_tx.sv
// replay_uart_tx
//   Drains bytes from the 512x8 replay FIFO and serializes each one onto a
//   UART TX line as an 8N1 frame, LSB first. A replay request rewinds the
//   FIFO read pointer. The rewind is issued only between frames, so a frame
//   already in flight always completes.
//
// Ports
//   clk          system clock, all state changes on posedge
//   reset        asynchronous, active-low reset
//   enable       level, 1 permits starting new frames
//   replay_req   one-cycle pulse, request a FIFO rewind
//   fifo_rdata   FIFO read data, valid the cycle after fifo_read
//   fifo_emptyB  FIFO not-empty flag (1 = data available)
//   fifo_read    one-cycle FIFO read strobe
//   fifo_replay  one-cycle FIFO replay (rewind) strobe
//   txd          UART serial output, idle high
//   busy         high from FETCH through the end of STOP
//   byte_done    one-cycle pulse in the last cycle of each stop bit
module replay_uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       replay_req,
    input  logic [7:0] fifo_rdata,
    input  logic       fifo_emptyB,
    output logic       fifo_read,
    output logic       fifo_replay,
    output logic       txd,
    output logic       busy,
    output logic       byte_done
);

    localparam int BAUD_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [BAUD_W-1:0]   baud_r, baud_s;
    logic [2:0]          bit_r, bit_s;
    logic [7:0]          shift_r, shift_s;
    logic                replay_pend_r, replay_pend_s;
    logic                pend_s;
    logic                issue_replay_s;
    logic                baud_last_s;

    logic                txd_r, txd_s;
    logic                busy_r, busy_s;
    logic                fifo_read_r, fifo_read_s;
    logic                fifo_replay_r, fifo_replay_s;
    logic                byte_done_r, byte_done_s;

    assign txd         = txd_r;
    assign busy        = busy_r;
    assign fifo_read   = fifo_read_r;
    assign fifo_replay = fifo_replay_r;
    assign byte_done   = byte_done_r;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_s        = state_r;
        baud_s         = baud_r;
        bit_s          = bit_r;
        shift_s        = shift_r;
        // A request arriving this cycle counts as pending, so it is never lost
        // and repeated requests before service collapse into one.
        pend_s         = replay_pend_r | replay_req;
        replay_pend_s  = pend_s;
        issue_replay_s = 1'b0;
        baud_last_s    = (baud_r == BAUD_LAST);

        case (state_r)
            ST_IDLE: begin
                baud_s = BAUD_ZERO;
                bit_s  = 3'd0;
                if (pend_s) begin
                    issue_replay_s = 1'b1;
                    replay_pend_s  = 1'b0;
                end else if (fifo_replay_r) begin
                    // emptyB is stale while the rewind is being applied
                    state_s = ST_IDLE;
                end else if (enable && fifo_emptyB) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                shift_s = fifo_rdata;
                baud_s  = BAUD_ZERO;
                bit_s   = 3'd0;
                state_s = ST_START;
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_s  = BAUD_ZERO;
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_s  = BAUD_ZERO;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_s = BAUD_ZERO;
                    if (pend_s) begin
                        state_s = ST_IDLE;
                    end else if (enable && fifo_emptyB) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = BAUD_ZERO;
                bit_s   = 3'd0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies
        // line up exactly with the state they describe.
        fifo_read_s   = (state_s == ST_FETCH);
        fifo_replay_s = issue_replay_s;
        busy_s        = (state_s != ST_IDLE);
        byte_done_s   = (state_s == ST_STOP) && (baud_s == BAUD_LAST);
        case (state_s)
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = shift_s[0];
            default:  txd_s = 1'b1;
        endcase
    end

    // FSM state, counters, shift register and replay-pending flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            baud_r        <= BAUD_ZERO;
            bit_r         <= 3'd0;
            shift_r       <= 8'd0;
            replay_pend_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            baud_r        <= baud_s;
            bit_r         <= bit_s;
            shift_r       <= shift_s;
            replay_pend_r <= replay_pend_s;
        end
    end

    // Registered outputs; reset forces the line idle immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txd_r         <= 1'b1;
            busy_r        <= 1'b0;
            fifo_read_r   <= 1'b0;
            fifo_replay_r <= 1'b0;
            byte_done_r   <= 1'b0;
        end else begin
            txd_r         <= txd_s;
            busy_r        <= busy_s;
            fifo_read_r   <= fifo_read_s;
            fifo_replay_r <= fifo_replay_s;
            byte_done_r   <= byte_done_s;
        end
    end

endmodule
